// File: rtl/data_mem_ctrl_pkg.sv
// Shared load/store codes, FSM state encoding and lane helpers for the data memory controller.
// Also imported by control_unit so both sides agree on MR_*/MW_* encodings.
package data_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    NO_R   = 3'b000,
    MR_LB  = 3'b001,
    MR_LH  = 3'b010,
    MR_LW  = 3'b011,
    MR_LBU = 3'b100,
    MR_LHU = 3'b101
  } mem_read_e;

  typedef enum logic [1:0] {
    NO_W  = 2'b00,
    MW_SB = 2'b01,
    MW_SH = 2'b10,
    MW_SW = 2'b11
  } mem_write_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Codes 110/111 have no meaning and fold to "no load".
  function automatic mem_read_e norm_read(input logic [2:0] code);
    case (code)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101: norm_read = mem_read_e'(code);
      default:                                norm_read = NO_R;
    endcase
  endfunction

  function automatic size_e read_size(input mem_read_e code);
    case (code)
      MR_LB, MR_LBU: read_size = SZ_BYTE;
      MR_LH, MR_LHU: read_size = SZ_HALF;
      default:       read_size = SZ_WORD;
    endcase
  endfunction

  function automatic size_e write_size(input logic [1:0] code);
    case (code)
      MW_SB:   write_size = SZ_BYTE;
      MW_SH:   write_size = SZ_HALF;
      default: write_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: replicate = {4{d[7:0]}};
      SZ_HALF: replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-wide backing-memory bus: request held until a single-cycle ack returns read data.
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/data_mem_ctrl_load_formatter.sv
// Combinational lane select and sign/zero extension of a loaded word.
module data_mem_ctrl_load_formatter
  import data_mem_ctrl_pkg::*;
(
  input  mem_read_e   rcode,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (rcode)
      MR_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      MR_LH:   data = {{16{half_sel[15]}}, half_sel};
      MR_LW:   data = word;
      MR_LBU:  data = {24'd0, byte_sel};
      MR_LHU:  data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: latches a load/store, drives one memory access, returns formatted load data;
// min 3 cycles (IDLE/ACCESS/DONE), stalls the pipeline via busy_wait; DATA_MEM_MISALIGN_EN traps misaligned access.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            mem_read,
  input  logic [1:0]            mem_write,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  busy_wait,
  output logic                  misalign,
  data_mem_ctrl_if.master       mem
);

  state_e      state, state_nxt;
  mem_read_e   rcode_n;
  logic        is_store;
  logic        req_vld;
  size_e       req_size;
  logic [31:0] addr_fix;
  logic        go_mis;

  logic [31:0] lat_addr;
  logic [3:0]  lat_be;
  logic        lat_we;
  logic [31:0] lat_wdata;
  mem_read_e   lat_rcode;
  logic        lat_clear;
  logic [31:0] fmt_data;

  always_comb begin
    rcode_n  = norm_read(mem_read);
    is_store = (mem_write != NO_W);
    req_vld  = is_store || (rcode_n != NO_R);
    req_size = is_store ? write_size(mem_write) : read_size(rcode_n);
    // Offending low bits are dropped so lane selection always sees a natural alignment.
    addr_fix = address;
    case (req_size)
      SZ_HALF: addr_fix[0]   = 1'b0;
      SZ_WORD: addr_fix[1:0] = 2'b00;
      default: ;
    endcase
  end

`ifdef DATA_MEM_MISALIGN_EN
  assign go_mis = ((req_size == SZ_HALF) && address[0]) ||
                  ((req_size == SZ_WORD) && (address[1:0] != 2'b00));
`else
  assign go_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_wait = 1'b0;
    case (state)
      IDLE: begin
        if (req_vld) begin
          busy_wait = 1'b1;
          state_nxt = go_mis ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        busy_wait = 1'b1;
        if (mem.ack) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) busy_wait = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_rcode <= NO_R;
      lat_clear <= 1'b0;
      read_data <= '0;
    end else begin
      if ((state == IDLE) && req_vld) begin
        lat_addr  <= addr_fix;
        lat_be    <= lane_mask(req_size, addr_fix[1:0]);
        lat_we    <= is_store;
        lat_wdata <= is_store ? replicate(req_size, write_data) : '0;
        lat_rcode <= is_store ? NO_R : rcode_n;
        lat_clear <= is_store && (rcode_n != NO_R);
        if (go_mis) read_data <= '0;
      end
      // Pure stores leave the last load result in place; a combined load+store clears it.
      if ((state == ACCESS) && mem.ack) begin
        if (!lat_we)        read_data <= fmt_data;
        else if (lat_clear) read_data <= '0;
      end
    end
  end

`ifdef DATA_MEM_MISALIGN_EN
  logic mis_flag;

  always_ff @(posedge clk) begin
    if (reset)                            mis_flag <= 1'b0;
    else if ((state == IDLE) && req_vld)  mis_flag <= go_mis;
  end

  assign misalign = (state == DONE) && mis_flag;
`else
  assign misalign = 1'b0;
`endif

  data_mem_ctrl_load_formatter u_load_formatter (
    .rcode  (lat_rcode),
    .offset (lat_addr[1:0]),
    .word   (mem.rdata),
    .data   (fmt_data)
  );

  assign mem.req   = (state == ACCESS);
  assign mem.we    = (state == ACCESS) && lat_we;
  assign mem.addr  = (state == ACCESS) ? {lat_addr[31:2], 2'b00} : '0;
  assign mem.be    = (state == ACCESS) ? lat_be : '0;
  assign mem.wdata = (state == ACCESS) ? lat_wdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a transaction-level memory/format model and per-cycle compare.
module tb_data_mem_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy_wait;
  logic        misalign;

  data_mem_ctrl_if mif ();

  data_mem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busy_wait  (busy_wait),
    .misalign   (misalign),
    .mem        (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        exp_busy, exp_req, exp_we, exp_mis, exp_bus_chk, exp_wd_chk;
  logic [31:0] exp_addr, exp_wdata;
  logic [31:0] exp_rd = 32'h0;
  logic [3:0]  exp_be;

  logic [31:0] bmem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: byte sizes, lane masks and extension by plain arithmetic ----
  function automatic int m_size(input logic [2:0] r, input logic [1:0] w);
    if (w != 2'd0) return (w == 2'd1) ? 1 : (w == 2'd2) ? 2 : 4;
    case (r)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_mis(input int sz, input logic [31:0] a);
`ifdef DATA_MEM_MISALIGN_EN
    return (int'(a[1:0]) % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_off(input int sz, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    return o - (o % sz);
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
    int v;
    v = ((1 << sz) - 1) << m_off(sz, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    longint mask, r;
    mask = (longint'(1) << (8 * sz)) - 1;
    r = 0;
    for (int i = 0; i < 4; i += sz) r = r | ((longint'(d) & mask) << (8 * i));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] r, input logic [31:0] a, input logic [31:0] word);
    int sz;
    longint mask, v;
    sz = m_size(r, 2'd0);
    mask = (longint'(1) << (8 * sz)) - 1;
    v = (longint'(word) >> (8 * m_off(sz, a))) & mask;
    if (((r == 3'd1) || (r == 3'd2)) && v[8 * sz - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---- single compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_wait", 32'(busy_wait), 32'(exp_busy));
      chk("misalign",  32'(misalign),  32'(exp_mis));
      chk("mem_req",   32'(mif.req),   32'(exp_req));
      chk("mem_we",    32'(mif.we),    32'(exp_we));
      chk("read_data", read_data,      exp_rd);
      if (exp_bus_chk) begin
        chk("mem_addr", mif.addr,      exp_addr);
        chk("mem_be",   32'(mif.be),   32'(exp_be));
        if (exp_wd_chk) chk("mem_wdata", mif.wdata, exp_wdata);
      end
    end
  end

  task automatic set_quiet_exp();
    exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_mis = 1'b0;
    exp_bus_chk = 1'b1; exp_wd_chk = 1'b1;
    exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
  endtask

  // One full transaction; ack lands in ACCESS cycle number lat (0 = first).
  task automatic do_op(input logic [2:0] r, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, input int lat, output int busy_n);
    logic        st;
    logic [2:0]  rn;
    int          sz;
    bit          mis;
    logic [31:0] ea, ewd, word, key;
    logic [3:0]  ebe;
    rn  = (r > 3'd5) ? 3'd0 : r;
    st  = (w != 2'd0);
    sz  = m_size(rn, w);
    mis = m_mis(sz, a);
    ea  = {a[31:2], 2'b00};
    key = {2'b00, a[31:2]};
    ebe = m_be(sz, a);
    ewd = m_wdata(sz, d);
    word = bmem.exists(key) ? bmem[key] : 32'h0;
    busy_n = 0;

    @(posedge clk); #1;
    mem_read = r; mem_write = w; address = a; write_data = d;
    mif.ack = 1'b0; mif.rdata = 32'h0;
    exp_busy = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_bus_chk = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    if (busy_wait) busy_n++;

    if (!mis) begin
      for (int k = 0; k <= lat; k++) begin
        @(posedge clk); #1;
        mem_read = 3'd0; mem_write = 2'd0; address = ~a; write_data = ~d;
        exp_busy = 1'b1; exp_req = 1'b1; exp_we = st;
        exp_bus_chk = 1'b1; exp_wd_chk = st;
        exp_addr = ea; exp_be = ebe; exp_wdata = ewd;
        mif.ack   = (k == lat);
        mif.rdata = (k == lat) ? word : (32'hA5A5_0000 + 32'(k));
        @(negedge clk); #1;
        if (busy_wait) busy_n++;
      end
    end

    if (mis) exp_rd = 32'h0;
    else if (st) begin
      if (rn != 3'd0) exp_rd = 32'h0;
      for (int i = 0; i < 4; i++) if (ebe[i]) word[8*i +: 8] = ewd[8*i +: 8];
      bmem[key] = word;
    end else exp_rd = m_load(rn, a, word);

    // DONE: a stray ack and any request here must be ignored
    @(posedge clk); #1;
    mem_read = 3'd0; mem_write = 2'd0;
    mif.ack = 1'b1; mif.rdata = 32'hFFFF_0000;
    exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_bus_chk = 1'b0; exp_mis = mis;
    @(negedge clk); #1;
    if (busy_wait) busy_n++;
    chk_en = 1'b0;
  endtask

  task automatic idle_cycle(input logic [2:0] r, input logic [1:0] w, input logic [31:0] a);
    @(posedge clk); #1;
    mem_read = r; mem_write = w; address = a; write_data = 32'h1111_2222;
    mif.ack = 1'b0;
    exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_bus_chk = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk_en = 1'b0;
  endtask

  initial begin
    int bn;
    reset = 1'b1;
    mem_read = 3'd0; mem_write = 2'd0; address = 32'h0; write_data = 32'h0;
    mif.ack = 1'b0; mif.rdata = 32'h0;
    bmem[32'h80] = 32'h80F0_7F01;
    bmem[32'hC0] = 32'h0000_0000;

    // reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    set_quiet_exp(); exp_rd = 32'h0; chk_en = 1'b1;
    @(negedge clk); #1;
    chk_en = 1'b0;

    // model pins against hand-worked values
    chk("pin_lb",    m_load(3'd1, 32'h203, 32'h80F0_7F01), 32'hFFFF_FF80);
    chk("pin_lbu",   m_load(3'd4, 32'h203, 32'h80F0_7F01), 32'h0000_0080);
    chk("pin_lh",    m_load(3'd2, 32'h200, 32'h80F0_7F01), 32'h0000_7F01);
    chk("pin_lhu",   m_load(3'd5, 32'h202, 32'h80F0_7F01), 32'h0000_80F0);
    chk("pin_sb_be", 32'(m_be(1, 32'h301)), 32'h2);
    chk("pin_sb_wd", m_wdata(1, 32'h0000_00AB), 32'hABAB_ABAB);
    chk("pin_sh_be", 32'(m_be(2, 32'h102)), 32'hC);

    // SW with ack two cycles into ACCESS
    do_op(3'd0, 2'd3, 32'h100, 32'hDEAD_BEEF, 2, bn);
    chk("sw_busy_cycles", 32'(bn), 32'd4);

    // loads from 0x200 = 0x80F07F01
    do_op(3'd1, 2'd0, 32'h203, 32'h0, 0, bn);
    chk("lb_203", read_data, 32'hFFFF_FF80);
    chk("min_busy_cycles", 32'(bn), 32'd2);
    do_op(3'd4, 2'd0, 32'h203, 32'h0, 1, bn);
    chk("lbu_203", read_data, 32'h0000_0080);
    do_op(3'd2, 2'd0, 32'h200, 32'h0, 0, bn);
    chk("lh_200", read_data, 32'h0000_7F01);
    do_op(3'd5, 2'd0, 32'h202, 32'h0, 3, bn);
    chk("lhu_202", read_data, 32'h0000_80F0);

    // reset while in ACCESS, then a late ack
    @(posedge clk); #1;
    mem_read = 3'd3; mem_write = 2'd0; address = 32'h200; mif.ack = 1'b0;
    exp_busy = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_bus_chk = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    mem_read = 3'd0;
    exp_req = 1'b1; exp_bus_chk = 1'b1; exp_wd_chk = 1'b0; exp_addr = 32'h200; exp_be = 4'hF;
    @(posedge clk); #1;
    chk_en = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mif.ack = 1'b1; mif.rdata = 32'h1234_5678;
    set_quiet_exp(); exp_rd = 32'h0; chk_en = 1'b1;
    @(posedge clk); #1;
    mif.ack = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b0;
    chk("rst_read_data", read_data, 32'h0);

    // byte and halfword stores, read back as words
    do_op(3'd0, 2'd1, 32'h301, 32'h0000_00AB, 1, bn);
    do_op(3'd3, 2'd0, 32'h300, 32'h0, 0, bn);
    chk("lw_after_sb", read_data, 32'h0000_AB00);
    do_op(3'd0, 2'd2, 32'h102, 32'h0000_1234, 0, bn);
    do_op(3'd3, 2'd0, 32'h100, 32'h0, 2, bn);
    chk("lw_after_sh", read_data, 32'h1234_BEEF);

    // misaligned word load
    do_op(3'd3, 2'd0, 32'h102, 32'h0, 1, bn);
`ifdef DATA_MEM_MISALIGN_EN
    chk("lw_misaligned", read_data, 32'h0);
`else
    chk("lw_misaligned", read_data, 32'h1234_BEEF);
`endif

    // load and store together behaves as a store and clears read_data
    do_op(3'd3, 2'd0, 32'h100, 32'h0, 0, bn);
    do_op(3'd3, 2'd3, 32'h400, 32'h1234_5678, 0, bn);
    chk("combined_rd", read_data, 32'h0);
    do_op(3'd3, 2'd0, 32'h400, 32'h0, 1, bn);
    chk("lw_after_combined", read_data, 32'h1234_5678);

    // undefined load codes are not requests
    idle_cycle(3'b110, 2'd0, 32'h200);
    idle_cycle(3'b111, 2'd0, 32'h200);
    idle_cycle(3'b000, 2'd0, 32'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 MEM_READ  input  3  load code from control unit: NO_R, MR_LB, MR_LH, MR_LW, MR_LBU, MR_LHU.
REQ-004 MEM_WRITE  input  2  store code from control unit: NO_W, MW_SB, MW_SH, MW_SW.
REQ-005 ADDRESS  input  32  byte address from ALU result.
REQ-006 WRITE_DATA  input  32  store data (rs2 value).
REQ-007 READ_DATA  output  32  aligned, extended load result.
REQ-008 BUSY_WAIT  output  1  pipeline stall request.
REQ-009 MISALIGN  output  1  one-cycle pulse on misaligned access (see REQ-030).
REQ-010 MEM_REQ, MEM_WE  output  1 each  backing-memory request and write strobe.
REQ-011 MEM_ADDR  output  32  word address, bits [1:0] always 0.
REQ-012 MEM_BE  output  4  byte enables, bit n = byte lane n (little-endian).
REQ-013 MEM_WDATA  output  32  lane-replicated store data.
REQ-014 MEM_RDATA  input  32  word read data, valid with MEM_ACK.
REQ-015 MEM_ACK  input  1  single-cycle completion from backing memory, any latency >= 0 cycles after MEM_REQ.

Function
REQ-016 States: IDLE, ACCESS, DONE.
REQ-017 Request valid when MEM_READ != NO_R or MEM_WRITE != NO_W; both non-zero: treat as store, READ_DATA = 0.
REQ-018 IDLE with valid request: BUSY_WAIT = 1 combinationally in same cycle; latch address, data, codes; next state ACCESS.
REQ-019 ACCESS: MEM_REQ = 1, MEM_WE/MEM_ADDR/MEM_BE/MEM_WDATA from latched values, held stable until MEM_ACK; BUSY_WAIT = 1.
REQ-020 ACCESS with MEM_ACK = 1: capture and format MEM_RDATA into READ_DATA register; next state DONE.
REQ-021 DONE: BUSY_WAIT = 0, MEM_REQ = 0, READ_DATA valid; inputs ignored; next state IDLE unconditionally.
REQ-022 Minimum occupancy 3 cycles (ack in first ACCESS cycle); READ_DATA holds until next load completes.
REQ-023 Byte enables: SB 4'b0001 << A[1:0]; SH 4'b0011 << A[1:0]; SW 4'b1111; loads use the same masks; MEM_WE = 1 only for stores.
REQ-024 MEM_WDATA: SB replicates byte 4x; SH replicates halfword 2x; SW passes through.
REQ-025 Load format: LB/LH sign-extend selected lane; LBU/LHU zero-extend; LW passes word.
REQ-026 MEM_ACK outside ACCESS ignored; inputs need not be held by requester after IDLE latch.
REQ-027 Undefined MEM_READ codes (110, 111) treated as NO_R.

Reset
REQ-028 RESET at any edge, including mid-ACCESS: state IDLE; MEM_REQ, MEM_WE, BUSY_WAIT, MISALIGN = 0; MEM_BE = 0; MEM_ADDR, MEM_WDATA, READ_DATA = 0.
REQ-029 In-flight access abandoned; ack after reset ignored (REQ-026).

Configuration
REQ-030 DATA_MEM_MISALIGN_EN defined: halfword with A[0]=1 or word with A[1:0]!=0 -> no ACCESS, IDLE -> DONE directly, MISALIGN = 1 during DONE, READ_DATA = 0, no memory write.
REQ-031 DATA_MEM_MISALIGN_EN undefined: MISALIGN tied 0; offending low address bits cleared (halfword A[0], word A[1:0]) before lane selection.

Structure
REQ-032 MR_*/MW_* codes and state encodings live in shared macros/encodings package used by control_unit: NO_R=000, MR_LB=001, MR_LH=010, MR_LW=011, MR_LBU=100, MR_LHU=101; NO_W=00, MW_SB=01, MW_SH=10, MW_SW=11.
REQ-033 One sub-module, load_formatter: combinational lane select + extension (REQ-025).

Verification
REQ-034 SW A=0x100, D=0xDEADBEEF, ack after 2 cycles -> MEM_BE=1111, MEM_ADDR=0x100, MEM_WE=1, BUSY_WAIT high 4 cycles then low.
REQ-035 Memory word 0x80F0_7F01 at 0x200: LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080; LH 0x200 -> 0x00007F01; LHU 0x202 -> 0x000080F0.
REQ-036 SB A=0x301, D=0x000000AB -> MEM_BE=0010, MEM_WDATA=0xABABABAB, MEM_ADDR=0x300.
REQ-037 LW A=0x102, macro on -> MISALIGN pulse, MEM_REQ never asserts; macro off -> MEM_ADDR=0x100, BE=1111.
REQ-038 RESET during ACCESS, then late MEM_ACK -> IDLE, BUSY_WAIT=0, READ_DATA=0, ack ignored.
REQ-039 MEM_READ=MR_LW and MEM_WRITE=MW_SW together -> store performed, READ_DATA=0.
